// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with load-use hazard bubble, branch flush
//            squash and a saturating load-use stall counter.
// Revision : 1.0
// ============================================================================
module id_ex_stage #(
    parameter int DATA_WIDTH      = 64,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       id_Reg2Loc,
    input  logic                       id_ALUSrc,
    input  logic                       id_MemtoReg,
    input  logic                       id_Branch,
    input  logic                       id_MemRead,
    input  logic                       id_MemWrite,
    input  logic                       id_RegWrite,
    input  logic                       id_Uncondbranch,
    input  logic                       id_Branchlink,
    input  logic                       id_Branchreg,
    input  logic                       id_not_zero,
    input  logic                       id_CB_instr,
    input  logic [1:0]                 id_ALUOp,
    input  logic [10:0]                id_opcode,
    input  logic [DATA_WIDTH-1:0]      id_pc,
    input  logic [DATA_WIDTH-1:0]      id_rdata1,
    input  logic [DATA_WIDTH-1:0]      id_rdata2,
    input  logic [DATA_WIDTH-1:0]      id_imm,
    input  logic [4:0]                 id_rn,
    input  logic [4:0]                 id_reg2,
    input  logic [4:0]                 id_rd,
    output logic                       ex_ALUSrc,
    output logic                       ex_MemtoReg,
    output logic                       ex_Branch,
    output logic                       ex_MemRead,
    output logic                       ex_MemWrite,
    output logic                       ex_RegWrite,
    output logic                       ex_Uncondbranch,
    output logic                       ex_Branchlink,
    output logic                       ex_Branchreg,
    output logic                       ex_not_zero,
    output logic                       ex_CB_instr,
    output logic [1:0]                 ex_ALUOp,
    output logic [10:0]                ex_opcode,
    output logic [DATA_WIDTH-1:0]      ex_pc,
    output logic [DATA_WIDTH-1:0]      ex_rdata1,
    output logic [DATA_WIDTH-1:0]      ex_rdata2,
    output logic [DATA_WIDTH-1:0]      ex_imm,
    output logic [4:0]                 ex_rn,
    output logic [4:0]                 ex_reg2,
    output logic [4:0]                 ex_rd,
    output logic                       ex_valid,
    output logic                       pc_write,
    output logic                       if_id_write,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    localparam int                       C_CTRL_W = 13;
    localparam logic [4:0]               C_XZR    = 5'd31;
    localparam logic [STALL_CNT_WIDTH-1:0] C_CNT_MAX = {STALL_CNT_WIDTH{1'b1}};

    logic [C_CTRL_W-1:0]        ctrl_d, ctrl_q;
    logic                       valid_d, valid_q;
    logic [STALL_CNT_WIDTH-1:0] stall_d, stall_q;
    logic [10:0]                opcode_q;
    logic [DATA_WIDTH-1:0]      pc_q, rdata1_q, rdata2_q, imm_q;
    logic [4:0]                 rn_q, reg2_q, rd_q;

    logic w_reg2_used;
    logic w_hazard;
    logic w_bubble;

    // Only the registered load's destination matters; XZR reads are always zero.
    assign w_reg2_used = id_Reg2Loc | ~id_ALUSrc;
    assign w_hazard    = ctrl_q[9] & valid_q & (rd_q != C_XZR) &
                         ((rd_q == id_rn) | (w_reg2_used & (rd_q == id_reg2)));
    assign w_bubble    = flush | w_hazard;

    // A flush discards the stalled instruction, so it must never freeze fetch.
    assign pc_write    = reset | flush | ~w_hazard;
    assign if_id_write = pc_write;

    always_comb begin
        ctrl_d  = {C_CTRL_W{1'b0}};
        valid_d = 1'b0;
        stall_d = stall_q;
        if (!w_bubble) begin
            ctrl_d  = {id_ALUSrc, id_MemtoReg, id_Branch, id_MemRead, id_MemWrite,
                       id_RegWrite, id_Uncondbranch, id_Branchlink, id_Branchreg,
                       id_not_zero, id_CB_instr, id_ALUOp};
            valid_d = 1'b1;
        end
        if (w_hazard && !flush && (stall_q != C_CNT_MAX)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_q   <= '0;
            valid_q  <= 1'b0;
            stall_q  <= '0;
            opcode_q <= '0;
            pc_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            rn_q     <= '0;
            reg2_q   <= '0;
            rd_q     <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            valid_q  <= valid_d;
            stall_q  <= stall_d;
            opcode_q <= id_opcode;
            pc_q     <= id_pc;
            rdata1_q <= id_rdata1;
            rdata2_q <= id_rdata2;
            imm_q    <= id_imm;
            rn_q     <= id_rn;
            reg2_q   <= id_reg2;
            rd_q     <= id_rd;
        end
    end

    assign {ex_ALUSrc, ex_MemtoReg, ex_Branch, ex_MemRead, ex_MemWrite,
            ex_RegWrite, ex_Uncondbranch, ex_Branchlink, ex_Branchreg,
            ex_not_zero, ex_CB_instr, ex_ALUOp} = ctrl_q;

    assign ex_valid    = valid_q;
    assign ex_opcode   = opcode_q;
    assign ex_pc       = pc_q;
    assign ex_rdata1   = rdata1_q;
    assign ex_rdata2   = rdata2_q;
    assign ex_imm      = imm_q;
    assign ex_rn       = rn_q;
    assign ex_reg2     = reg2_q;
    assign ex_rd       = rd_q;
    assign stall_count = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Scoreboard bench for id_ex_stage (hazard, flush, pass-through,
//            saturating stall counter). Counter width reduced to keep runtime short.
// Revision : 1.0
// ============================================================================
module tb_id_ex_stage;

    localparam int DW  = 64;
    localparam int SCW = 10;
    localparam logic [SCW-1:0] C_SAT = {SCW{1'b1}};

    typedef struct {
        logic        reg2loc, alusrc, memtoreg, branch, memread, memwrite, regwrite;
        logic        uncond, blink, breg, notzero, cb;
        logic [1:0]  aluop;
        logic [10:0] opcode;
        logic [DW-1:0] pc, r1, r2, imm;
        logic [4:0]  rn, reg2, rd;
    } instr_t;

    typedef struct {
        logic          valid;
        logic [12:0]   ctrl;
        logic [10:0]   opcode;
        logic [DW-1:0] pc, r1, r2, imm;
        logic [4:0]    rn, reg2, rd;
        logic [SCW-1:0] stall;
    } exp_t;

    logic clk = 1'b0;
    logic rst, flush;
    logic id_Reg2Loc, id_ALUSrc, id_MemtoReg, id_Branch, id_MemRead, id_MemWrite;
    logic id_RegWrite, id_Uncondbranch, id_Branchlink, id_Branchreg, id_not_zero, id_CB_instr;
    logic [1:0]  id_ALUOp;
    logic [10:0] id_opcode;
    logic [DW-1:0] id_pc, id_rdata1, id_rdata2, id_imm;
    logic [4:0]  id_rn, id_reg2, id_rd;
    logic ex_ALUSrc, ex_MemtoReg, ex_Branch, ex_MemRead, ex_MemWrite, ex_RegWrite;
    logic ex_Uncondbranch, ex_Branchlink, ex_Branchreg, ex_not_zero, ex_CB_instr;
    logic [1:0]  ex_ALUOp;
    logic [10:0] ex_opcode;
    logic [DW-1:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0]  ex_rn, ex_reg2, ex_rd;
    logic ex_valid, pc_write, if_id_write;
    logic [SCW-1:0] stall_count;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_WIDTH(DW), .STALL_CNT_WIDTH(SCW)) u_dut (
        .clock(clk), .reset(rst), .flush(flush),
        .id_Reg2Loc(id_Reg2Loc), .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg),
        .id_Branch(id_Branch), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .id_RegWrite(id_RegWrite), .id_Uncondbranch(id_Uncondbranch),
        .id_Branchlink(id_Branchlink), .id_Branchreg(id_Branchreg),
        .id_not_zero(id_not_zero), .id_CB_instr(id_CB_instr), .id_ALUOp(id_ALUOp),
        .id_opcode(id_opcode), .id_pc(id_pc), .id_rdata1(id_rdata1),
        .id_rdata2(id_rdata2), .id_imm(id_imm), .id_rn(id_rn), .id_reg2(id_reg2),
        .id_rd(id_rd),
        .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg), .ex_Branch(ex_Branch),
        .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_RegWrite(ex_RegWrite),
        .ex_Uncondbranch(ex_Uncondbranch), .ex_Branchlink(ex_Branchlink),
        .ex_Branchreg(ex_Branchreg), .ex_not_zero(ex_not_zero), .ex_CB_instr(ex_CB_instr),
        .ex_ALUOp(ex_ALUOp), .ex_opcode(ex_opcode), .ex_pc(ex_pc),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_rn(ex_rn), .ex_reg2(ex_reg2), .ex_rd(ex_rd), .ex_valid(ex_valid),
        .pc_write(pc_write), .if_id_write(if_id_write), .stall_count(stall_count)
    );

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    // Reference state: what EX should hold after each edge.
    logic           m_valid, m_memread;
    logic [4:0]     m_rd;
    logic [SCW-1:0] m_stall;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic instr_t mk_nop();
        instr_t i;
        i = '{default: '0};
        return i;
    endfunction

    function automatic instr_t mk_add(input logic [4:0] rn, reg2, rd, input logic [DW-1:0] a, b);
        instr_t i = mk_nop();
        i.opcode = 11'b10001011000; i.regwrite = 1'b1; i.aluop = 2'b10;
        i.rn = rn; i.reg2 = reg2; i.rd = rd; i.r1 = a; i.r2 = b;
        i.pc = 64'h1000 + {a[15:0], 2'b00}; i.imm = b ^ 64'h55;
        return i;
    endfunction

    function automatic instr_t mk_ldur(input logic [4:0] rn, rd);
        instr_t i = mk_nop();
        i.opcode = 11'b11111000010; i.memread = 1'b1; i.regwrite = 1'b1; i.alusrc = 1'b1;
        i.memtoreg = 1'b1; i.rn = rn; i.rd = rd; i.reg2 = 5'd0; i.imm = 64'd8;
        return i;
    endfunction

    task automatic drive(input instr_t i);
        id_Reg2Loc = i.reg2loc; id_ALUSrc = i.alusrc; id_MemtoReg = i.memtoreg;
        id_Branch = i.branch; id_MemRead = i.memread; id_MemWrite = i.memwrite;
        id_RegWrite = i.regwrite; id_Uncondbranch = i.uncond; id_Branchlink = i.blink;
        id_Branchreg = i.breg; id_not_zero = i.notzero; id_CB_instr = i.cb;
        id_ALUOp = i.aluop; id_opcode = i.opcode; id_pc = i.pc; id_rdata1 = i.r1;
        id_rdata2 = i.r2; id_imm = i.imm; id_rn = i.rn; id_reg2 = i.reg2; id_rd = i.rd;
    endtask

    task automatic compare_ex(input string tag);
        exp_t e;
        logic [12:0] c;
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb_q.pop_front();
        c = {ex_ALUSrc, ex_MemtoReg, ex_Branch, ex_MemRead, ex_MemWrite, ex_RegWrite,
             ex_Uncondbranch, ex_Branchlink, ex_Branchreg, ex_not_zero, ex_CB_instr, ex_ALUOp};
        check_val({tag, "_valid"}, {63'd0, ex_valid}, {63'd0, e.valid});
        check_val({tag, "_ctrl"}, {51'd0, c}, {51'd0, e.ctrl});
        check_val({tag, "_stall"}, {{(DW-SCW){1'b0}}, stall_count}, {{(DW-SCW){1'b0}}, e.stall});
        if (e.valid) begin
            check_val({tag, "_opcode"}, {53'd0, ex_opcode}, {53'd0, e.opcode});
            check_val({tag, "_pc"}, ex_pc, e.pc);
            check_val({tag, "_rdata1"}, ex_rdata1, e.r1);
            check_val({tag, "_rdata2"}, ex_rdata2, e.r2);
            check_val({tag, "_imm"}, ex_imm, e.imm);
            check_val({tag, "_regs"}, {49'd0, ex_rn, ex_reg2, ex_rd}, {49'd0, e.rn, e.reg2, e.rd});
        end
    endtask

    // One pipeline cycle: drive at negedge, check fetch-freeze, predict EX, compare after edge.
    task automatic step(input string tag, input instr_t i, input logic fl);
        exp_t e;
        logic hz, exp_pcw;
        @(negedge clk);
        rst = 1'b0; flush = fl; drive(i);
        #1;
        hz = m_memread && m_valid && (m_rd != 5'd31) &&
             ((m_rd == i.rn) || ((i.reg2loc || !i.alusrc) && (m_rd == i.reg2)));
        exp_pcw = fl || !hz;
        check_val({tag, "_pc_write"}, {63'd0, pc_write}, {63'd0, exp_pcw});
        check_val({tag, "_if_id_write"}, {63'd0, if_id_write}, {63'd0, exp_pcw});
        e = '{default: '0};
        if (hz && !fl && m_stall != C_SAT) m_stall = m_stall + 1'b1;
        e.stall = m_stall;
        if (!(fl || hz)) begin
            e.valid = 1'b1;
            e.ctrl = {i.alusrc, i.memtoreg, i.branch, i.memread, i.memwrite, i.regwrite,
                      i.uncond, i.blink, i.breg, i.notzero, i.cb, i.aluop};
            e.opcode = i.opcode; e.pc = i.pc; e.r1 = i.r1; e.r2 = i.r2; e.imm = i.imm;
            e.rn = i.rn; e.reg2 = i.reg2; e.rd = i.rd;
        end
        m_valid = e.valid; m_memread = e.valid && i.memread; m_rd = i.rd;
        sb_q.push_back(e);
        @(posedge clk); #1;
        compare_ex(tag);
    endtask

    task automatic reset_cycle(input string tag);
        exp_t e;
        @(negedge clk);
        rst = 1'b1; flush = 1'b0;
        #1;
        check_val({tag, "_pc_write_rst"}, {63'd0, pc_write}, 64'd1);
        check_val({tag, "_if_id_write_rst"}, {63'd0, if_id_write}, 64'd1);
        e = '{default: '0};
        e.valid = 1'b1;                 // reset clears every data field, so compare them all
        m_valid = 1'b0; m_memread = 1'b0; m_rd = 5'd0; m_stall = '0;
        sb_q.push_back(e);
        @(posedge clk); #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_val({tag, "_valid"}, {63'd0, ex_valid}, 64'd0);
            check_val({tag, "_stall"}, {{(DW-SCW){1'b0}}, stall_count}, 64'd0);
            check_val({tag, "_ctrl"}, {51'd0, ex_ALUSrc, ex_MemtoReg, ex_Branch, ex_MemRead,
                      ex_MemWrite, ex_RegWrite, ex_Uncondbranch, ex_Branchlink, ex_Branchreg,
                      ex_not_zero, ex_CB_instr, ex_ALUOp}, {51'd0, e.ctrl});
            check_val({tag, "_data"}, ex_pc | ex_rdata1 | ex_rdata2 | ex_imm, e.pc);
            check_val({tag, "_idx"}, {42'd0, ex_opcode, ex_rn, ex_reg2, ex_rd}, 64'd0);
        end
    endtask

    initial begin
        instr_t i;
        rst = 1'b1; flush = 1'b0; drive(mk_nop());
        m_valid = 1'b0; m_memread = 1'b0; m_rd = '0; m_stall = '0;

        reset_cycle("rst0");
        reset_cycle("rst1");

        step("add", mk_add(5'd1, 5'd2, 5'd3, 64'd5, 64'd7), 1'b0);

        // Load-use on rn: one bubble, then the held ADD proceeds.
        step("ldur_x4", mk_ldur(5'd0, 5'd4), 1'b0);
        step("lu_stall", mk_add(5'd4, 5'd2, 5'd6, 64'd11, 64'd12), 1'b0);
        step("lu_proceed", mk_add(5'd4, 5'd2, 5'd6, 64'd11, 64'd12), 1'b0);

        // Load-use through reg2.
        step("ldur_x9", mk_ldur(5'd1, 5'd9), 1'b0);
        step("lu2_stall", mk_add(5'd3, 5'd9, 5'd10, 64'd1, 64'd2), 1'b0);
        step("lu2_proceed", mk_add(5'd3, 5'd9, 5'd10, 64'd1, 64'd2), 1'b0);

        // XZR destination never stalls.
        step("ldur_xzr", mk_ldur(5'd0, 5'd31), 1'b0);
        step("xzr_use", mk_add(5'd31, 5'd31, 5'd7, 64'd3, 64'd4), 1'b0);

        // Unused reg2 (I-type) never stalls.
        step("ldur_x5", mk_ldur(5'd0, 5'd5), 1'b0);
        i = mk_add(5'd6, 5'd5, 5'd8, 64'd9, 64'd10);
        i.alusrc = 1'b1; i.reg2loc = 1'b0; i.opcode = 11'b10010001000;
        step("itype_nouse", i, 1'b0);

        // Flush wins over a simultaneous hazard.
        step("ldur_x4b", mk_ldur(5'd0, 5'd4), 1'b0);
        step("flush_hz", mk_add(5'd4, 5'd4, 5'd2, 64'd1, 64'd1), 1'b1);
        step("flush_plain", mk_add(5'd1, 5'd2, 5'd3, 64'd8, 64'd9), 1'b1);

        // Back-to-back load-use chain: each pair stalls once.
        step("chain_ld1", mk_ldur(5'd0, 5'd11), 1'b0);
        step("chain_ld2_st", mk_ldur(5'd11, 5'd12), 1'b0);
        step("chain_ld2", mk_ldur(5'd11, 5'd12), 1'b0);
        step("chain_use_st", mk_add(5'd12, 5'd0, 5'd13, 64'd2, 64'd3), 1'b0);
        step("chain_use", mk_add(5'd12, 5'd0, 5'd13, 64'd2, 64'd3), 1'b0);

        // CBNZ control pass-through.
        i = mk_nop();
        i.cb = 1'b1; i.branch = 1'b1; i.notzero = 1'b1; i.aluop = 2'b01; i.reg2loc = 1'b1;
        i.reg2 = 5'd7; i.opcode = 11'b10110101000; i.pc = 64'h2000; i.imm = 64'hFFFF_FFFF_FFFF_FFF0;
        step("cbnz", i, 1'b0);

        for (int k = 0; k < 6; k++) begin
            step("rand_add", mk_add(5'($urandom_range(0, 30)), 5'($urandom_range(0, 30)),
                 5'($urandom_range(0, 30)), {$urandom, $urandom}, {$urandom, $urandom}), 1'b0);
        end

        // Drive the stall counter into saturation with a self-dependent load stream.
        for (int k = 0; k < 2 * (1 << SCW) + 8; k++) begin
            step("sat", mk_ldur(5'd4, 5'd4), 1'b0);
        end
        check_val("sat_final", {{(DW-SCW){1'b0}}, stall_count}, {{(DW-SCW){1'b0}}, C_SAT});

        // Reset during a pending stall.
        step("pre_rst_ld", mk_ldur(5'd0, 5'd4), 1'b0);
        @(negedge clk);
        drive(mk_add(5'd4, 5'd4, 5'd1, 64'd1, 64'd1));
        reset_cycle("rst_mid_stall");
        step("post_rst", mk_add(5'd4, 5'd4, 5'd1, 64'd1, 64'd1), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX boundary of the pipelined ARMv8 core. Sits directly downstream of the decode control unit and the register file.
- Captures the decoded control bundle and the operands into EX-stage registers every cycle.
- Detects load-use hazards and inserts a bubble while freezing PC and IF/ID.
- Squashes the captured instruction when a taken branch flushes the pipe.

Parameters:
- DATA_WIDTH, 64, width of register operands, sign-extended immediate and PC.
- STALL_CNT_WIDTH, 16, width of the saturating stall-statistics counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  taken branch resolved downstream; squash the ID instruction.
- id_Reg2Loc, id_ALUSrc, id_MemtoReg, id_Branch, id_MemRead, id_MemWrite, id_RegWrite, id_Uncondbranch, id_Branchlink, id_Branchreg, id_not_zero, id_CB_instr  in  1 each  decode control bundle.
- id_ALUOp  in  2  decode ALU op class.
- id_opcode  in  11  instruction[31:21].
- id_pc  in  DATA_WIDTH  PC of the ID instruction.
- id_rdata1, id_rdata2  in  DATA_WIDTH  register-file read data.
- id_imm  in  DATA_WIDTH  sign-extended immediate.
- id_rn, id_reg2, id_rd  in  5 each  first source, Reg2Loc-muxed second source, destination.
- ex_ALUSrc, ex_MemtoReg, ex_Branch, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_Uncondbranch, ex_Branchlink, ex_Branchreg, ex_not_zero, ex_CB_instr  out  1 each  registered controls.
- ex_ALUOp  out  2  registered ALU op class.
- ex_opcode  out  11  registered opcode.
- ex_pc, ex_rdata1, ex_rdata2, ex_imm  out  DATA_WIDTH  registered datapath values.
- ex_rn, ex_reg2, ex_rd  out  5 each  registered register indices, used by forwarding.
- ex_valid  out  1  EX holds a real instruction, not a bubble.
- pc_write  out  1  combinational; 0 freezes the PC.
- if_id_write  out  1  combinational; 0 freezes IF/ID.
- stall_count  out  STALL_CNT_WIDTH  number of load-use bubbles inserted.

Behaviour:
- Reset: all ex_* outputs 0, ex_valid 0 and stall_count 0. The combinational outputs pc_write and if_id_write evaluate to 1 while reset is held.
- Latency: one cycle. Values on id_* at edge N appear on ex_* after edge N.
- Hazard term, combinational:
  - reg2_used = id_Reg2Loc | ~id_ALUSrc.
  - hazard = ex_MemRead & ex_valid & (ex_rd != 31) & ((ex_rd == id_rn) | (reg2_used & ex_rd == id_reg2)).
  - Register 31 (XZR) never causes a hazard.
- Priority per edge is reset, then flush, then hazard, then normal.
- Normal: capture all id_*; ex_valid <= 1; pc_write = if_id_write = 1.
- flush = 1:
  - Capture a bubble: every control output 0, ex_valid 0.
  - Data, index and opcode registers may capture freely; their values are don't-care.
  - pc_write = if_id_write = 1, even if hazard is also true, because the stalled instruction is being discarded.
  - stall_count does not increment.
- hazard = 1 and flush = 0:
  - Capture a bubble as for flush.
  - pc_write = if_id_write = 0.
  - stall_count increments by 1, saturating at all-ones (no wrap).
- Hazard lasts exactly one cycle for a single load. After the bubble, ex_valid = 0 so hazard clears and the held ID instruction proceeds; forwarding covers the remaining distance.
- Back-to-back load-use, i.e. a load followed by a dependent load followed by a dependent use: each pair stalls independently for one cycle.
- Bubbles never assert ex_RegWrite, ex_MemWrite, ex_MemRead, ex_Branch, ex_Uncondbranch or ex_Branchreg. A squashed instruction therefore has no architectural effect.
- Reset asserted mid-stall: the next edge clears everything. pc_write and if_id_write are forced to 1 while reset is high.
- No internal FSM beyond the valid bit; stall state is purely ex_valid & ex_MemRead.

Test Plan:
- Reset then ADD: hold reset 2 cycles. Then drive ADD (opcode 11'b10001011000, RegWrite 1, ALUOp 2'b10, rn 1, reg2 2, rd 3, rdata1 5, rdata2 7). Next cycle: ex_RegWrite 1, ex_ALUOp 2'b10, ex_rdata1 5, ex_rdata2 7, ex_rd 3, ex_valid 1.
- Load-use: LDUR X4 (MemRead 1, rd 4) followed by ADD with rn 4. During the ADD's ID cycle: pc_write 0, if_id_write 0. Next edge: all ex controls 0, ex_valid 0, stall_count 1. The following edge captures the ADD.
- XZR and unused reg2: LDUR rd 31 followed by a use of rn 31 gives no stall. LDUR rd 5 followed by an I-type with id_ALUSrc 1, id_Reg2Loc 0 and reg2 5 gives no stall.
- Flush with hazard: load-use condition present and flush = 1. Result: pc_write 1, bubble captured, stall_count unchanged.
- CBNZ pass-through: CB_instr 1, Branch 1, not_zero 1, ALUOp 2'b01, Reg2Loc 1, reg2 7. Next cycle: ex_Branch 1, ex_not_zero 1, ex_CB_instr 1, ex_reg2 7.
- Saturation: preload 65534 stalls, then apply 3 more. stall_count reads 65535. Assert reset and stall_count reads 0.
